btn_evt_ctrl: RTL and testbench

Multi-channel debounce controller that time-shares one debounce evaluation datapath across NUM_CH raw mechanical inputs. A common prescaler issues sample ticks, and a scan scheduler walks every channel once per tick. Validated press/release transitions are pushed into a small event FIFO, which downstream logic drains with a valid/ready handshake. It sits between board-level switch inputs and the control logic that consumes key events.

---
 rtl/btn_evt_pkg.sv | 26 ++
 rtl/btn_evt_fifo.sv | 62 ++++++
 rtl/btn_evt_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_btn_evt_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared types for the button event controller.
// Holds the scheduler state encoding, the queued event record and the
// channel-index width helper used by the top and its FIFO.
package btn_evt_pkg;

    // Scan scheduler states
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } sched_state_t;

    // Channel field in the stored event is sized for up to 256 channels;
    // the top only exposes the low ch_width(NUM_CH) bits.
    localparam int EVT_CH_W_MAX = 8;

    typedef struct packed {
        logic [EVT_CH_W_MAX-1:0] ch;
        logic                    press;
    } evt_t;

    // Channel-index width, never narrower than one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// btn_evt_fifo: synchronous show-ahead FIFO of evt_t records.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. The head reads as zero while the FIFO is empty.
module btn_evt_fifo
    import btn_evt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  evt_t push_data,
    input  logic pop,
    output evt_t head,
    output logic valid,
    output logic full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign head    = valid ? mem[rd_ptr_reg] : '0;

    // Storage write; contents need no reset because the head is gated by valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping (power-of-two depth wraps naturally)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/btn_evt_ctrl.sv
// btn_evt_ctrl: multi-channel switch debouncer with one shared evaluation
// slot per channel per sample tick, and an event FIFO drained by valid/ready.
// Optional macro BTN_EVT_RELEASE_EN: when defined, release events are queued
// as well as presses; otherwise only presses reach the FIFO.
module btn_evt_ctrl
    import btn_evt_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int TICK_DIV   = 1000,
    parameter int STABLE_CNT = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           btn_in,
    output logic [NUM_CH-1:0]           db_state,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [ch_width(NUM_CH)-1:0] evt_ch,
    output logic                        evt_press,
    output logic                        overflow,
    input  logic                        clr_overflow
);
    localparam int IDX_W   = ch_width(NUM_CH);
    localparam int CNT_W   = $clog2(STABLE_CNT);
    localparam int PRESC_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(STABLE_CNT - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   LAST_CH  = IDX_W'(NUM_CH - 1);

    logic [NUM_CH-1:0]  sync1_reg;
    logic [NUM_CH-1:0]  sync2_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic               tick;
    sched_state_t       state_reg;
    logic [IDX_W-1:0]   ch_idx_reg;
    logic [NUM_CH-1:0]  slot;
    logic [NUM_CH-1:0]  flip;
    logic [NUM_CH-1:0]  db_bits;
    logic               push_req;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               overflow_reg;
    evt_t               push_evt;
    evt_t               head_evt;
    logic               unused_head;

    // Two-flop synchronizer for every raw switch input
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Sample-tick prescaler; the wrap cycle is the tick
    assign tick = (presc_reg == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Scan scheduler: one channel per cycle after each tick, ascending order
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            ch_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        state_reg  <= SCAN;
                        ch_idx_reg <= '0;
                    end
                end
                SCAN: begin
                    if (ch_idx_reg == LAST_CH) begin
                        state_reg  <= IDLE;
                        ch_idx_reg <= '0;
                    end else begin
                        ch_idx_reg <= ch_idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    ch_idx_reg <= '0;
                end
            endcase
        end
    end

    // Per-channel stability counter and debounced level
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic             db_reg;
            logic             mismatch;

            assign slot[gi]    = (state_reg == SCAN) && (ch_idx_reg == IDX_W'(gi));
            assign mismatch    = sync2_reg[gi] ^ db_reg;
            assign flip[gi]    = slot[gi] && mismatch && (cnt_reg == CNT_MAX);
            assign db_bits[gi] = db_reg;

            // Evaluate only in this channel's scan slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                    db_reg  <= 1'b0;
                end else if (slot[gi]) begin
                    if (!mismatch) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        db_reg  <= ~db_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign db_state = db_bits;

    // Build the candidate event; at most one flip bit is set per cycle
    always_comb begin
        push_evt       = '0;
        push_evt.ch    = EVT_CH_W_MAX'(ch_idx_reg);
        push_evt.press = |(flip & sync2_reg);
`ifdef BTN_EVT_RELEASE_EN
        push_req = |flip;
`else
        push_req = |(flip & sync2_reg);
`endif
    end

    assign pop  = evt_valid & evt_ready;
    assign drop = push_req & fifo_full & ~pop;

    btn_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head_evt),
        .valid     (evt_valid),
        .full      (fifo_full)
    );

    assign evt_ch = head_evt.ch[IDX_W-1:0];
`ifdef BTN_EVT_RELEASE_EN
    assign evt_press = head_evt.press;
`else
    assign evt_press = 1'b1;
`endif
    assign unused_head = ^{head_evt.ch, head_evt.press};

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clr_overflow) begin
            overflow_reg <= 1'b0;
        end
    end

    assign overflow = overflow_reg;

    // A scan must always finish before the next tick arrives
    a_no_tick_in_scan: assert property (@(posedge clk) disable iff (reset)
        !(tick && (state_reg == SCAN)));

endmodule

// File: tb/tb_btn_evt_ctrl.sv
// tb_btn_evt_ctrl: directed stimulus with an event scoreboard for btn_evt_ctrl.
// Expectations follow BTN_EVT_RELEASE_EN when it is defined for the build.
module tb_btn_evt_ctrl;

    localparam int NUM_CH     = 4;
    localparam int TICK_DIV   = 16;
    localparam int STABLE_CNT = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef BTN_EVT_RELEASE_EN
    localparam int REL_EN = 1;
`else
    localparam int REL_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_in = '0;
    logic [3:0] db_state;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_ch;
    logic       evt_press;
    logic       overflow;
    logic       clr_overflow = 1'b0;

    typedef struct {
        int ch;
        int press;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    btn_evt_ctrl #(
        .NUM_CH     (NUM_CH),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .db_state     (db_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .evt_press    (evt_press),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int ch, input int press);
        exp_t e;
        e.ch    = ch;
        e.press = press;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake pops the scoreboard
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            $display("evt ch=%0d press=%0d t=%0t", evt_ch, evt_press, $time);
            if (exp_q.size() == 0) begin
                check("unexpected_evt_ch", int'(evt_ch), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_ch", int'(evt_ch), mon_e.ch);
                check("evt_press", int'(evt_press), mon_e.press);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int r3;
        int n;

        // Reset state
        step(4);
        check("rst_db_state", int'(db_state), 0);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_ch", int'(evt_ch), 0);
        check("rst_evt_press", int'(evt_press), REL_EN ? 0 : 1);
        check("rst_overflow", int'(overflow), 0);
        reset = 1'b0;
        step(2);

        // Steady press on channel 2
        btn_in[2] = 1'b1;
        expect_evt(2, 1);
        step(40);
        check("t1_db2_early", int'(db_state[2]), 0);
        step(60);
        check("t1_db_state", int'(db_state), 4'b0100);
        btn_in[2] = 1'b0;
        if (REL_EN != 0) expect_evt(2, 0);
        step(100);
        check("t1_db_release", int'(db_state), 0);

        // Bouncing channel 1 never settles
        for (int k = 0; k < 15; k++) begin
            btn_in[1] = ~btn_in[1];
            step(20);
            check("t2_db1", int'(db_state[1]), 0);
        end
        btn_in[1] = 1'b0;
        step(30);
        check("t2_db_state", int'(db_state), 0);

        // Channels 0 and 3 together: ordered events, flips 3 clk apart
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;
        expect_evt(0, 1);
        expect_evt(3, 1);
        r0 = -1;
        r3 = -1;
        for (int i = 0; i < 150; i++) begin
            step(1);
            if (r0 < 0 && db_state[0]) r0 = i;
            if (r3 < 0 && db_state[3]) r3 = i;
        end
        check("t4_both_rose", int'(r0 >= 0 && r3 >= 0), 1);
        check("t4_rise_gap", r3 - r0, 3);
        btn_in[0] = 1'b0;
        btn_in[3] = 1'b0;
        if (REL_EN != 0) begin
            expect_evt(0, 0);
            expect_evt(3, 0);
        end
        step(100);
        check("t4_db_release", int'(db_state), 0);
        check("t4_overflow", int'(overflow), 0);
        check("t4_sb_empty", exp_q.size(), 0);

        // Stalled consumer: fill the FIFO, then force drops
        evt_ready = 1'b0;
        btn_in = 4'hF;
        for (int c = 0; c < 4; c++) expect_evt(c, 1);
        step(100);
        check("t3_db_all", int'(db_state), 15);
        check("t3_valid_held", int'(evt_valid), 1);
        btn_in = 4'h0;
        step(100);
        check("t3_db_zero", int'(db_state), 0);
        check("t3_overflow_rel", int'(overflow), REL_EN);
        btn_in = 4'hF;
        step(100);
        btn_in = 4'h0;
        step(100);
        check("t3_overflow", int'(overflow), 1);
        check("t3_db_zero2", int'(db_state), 0);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        check("t3_overflow_clr", int'(overflow), 0);
        evt_ready = 1'b1;
        step(20);
        check("t3_drained", exp_q.size(), 0);
        check("t3_valid_low", int'(evt_valid), 0);

        // Reset in the middle of a count
        btn_in[1] = 1'b1;
        step(40);
        reset = 1'b1;
        step(2);
        check("t5_rst_db", int'(db_state), 0);
        check("t5_rst_valid", int'(evt_valid), 0);
        check("t5_rst_ovf", int'(overflow), 0);
        check("t5_rst_ch", int'(evt_ch), 0);
        expect_evt(1, 1);
        reset = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (db_state[1]) break;
        end
        check("t5_rise_cycle", n, 66);
        check("t5_db_state", int'(db_state), 4'b0010);
        btn_in[1] = 1'b0;
        if (REL_EN != 0) expect_evt(1, 0);
        step(100);
        check("t5_db_release", int'(db_state), 0);
        check("t5_overflow", int'(overflow), 0);

        step(10);
        check("final_sb_empty", exp_q.size(), 0);
        check("final_valid", int'(evt_valid), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
